// File: rtl/cacheline_adapter_if.sv
// Cacheline adapter bus: upstream line request/response plus downstream burst memory port.
// The adapter takes the slave view; the arbiter/memory side takes the master view.
interface cacheline_adapter_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
);
  logic [ADDR_W-1:0]  line_addr;
  logic               line_read;
  logic               line_write;
  logic [LINE_W-1:0]  line_wdata;
  logic [LINE_W-1:0]  line_rdata;
  logic               line_resp;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_read;
  logic               mem_write;
  logic [BURST_W-1:0] mem_wdata;
  logic [BURST_W-1:0] mem_rdata;
  logic               mem_resp;

  modport slave (
    input  line_addr, line_read, line_write, line_wdata, mem_rdata, mem_resp,
    output line_rdata, line_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output line_addr, line_read, line_write, line_wdata, mem_rdata, mem_resp,
    input  line_rdata, line_resp, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits one cacheline read/write into BEATS in-order bursts on the memory port
// and returns a single-cycle line_resp once the last beat has been taken.
module cacheline_adapter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adapter_if.slave bus
);
  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [BEATS-1:0][BURST_W-1:0]   wdata_q, wdata_d;
  logic [BEATS-1:0][BURST_W-1:0]   rdata_q, rdata_d;
  logic                            rd_q, rd_d;
  logic                            wr_q, wr_d;
  logic                            last_beat;

  // Byte-offset bits inside the line play no part in the burst address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.line_addr[OFF_W-1:0];

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.line_write) begin
          state_d = WR;
          wr_d    = 1'b1;
          addr_d  = {bus.line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d = bus.line_wdata;
          cnt_d   = '0;
        end else if (bus.line_read) begin
          state_d = RD;
          rd_d    = 1'b1;
          addr_d  = {bus.line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          cnt_d   = '0;
        end
      end
      RD: begin
        if (bus.mem_resp) begin
          rdata_d[cnt_q] = bus.mem_rdata;
          cnt_d          = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
            rd_d    = 1'b0;
          end
        end
      end
      WR: begin
        if (bus.mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
            wr_d    = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.line_rdata = rdata_q;
  assign bus.line_resp  = (state_q == DONE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_read   = rd_q;
  assign bus.mem_write  = wr_q;
  assign bus.mem_wdata  = (state_q == WR) ? wdata_q[cnt_q] : '0;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: transaction-level expectations updated by the
// stimulus tasks, a per-cycle compare on the falling edge, plus literal pins.
module tb_cacheline_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adapter_if #(.ADDR_W(32), .LINE_W(256), .BURST_W(64)) bus ();

  cacheline_adapter #(.ADDR_W(32), .LINE_W(256), .BURST_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected DUT-visible state, advanced by the stimulus tasks.
  logic [255:0] exp_rdata = '0;
  logic [255:0] exp_wline = '0;
  logic [31:0]  exp_addr  = '0;
  logic         exp_rd    = 1'b0;
  logic         exp_wr    = 1'b0;
  logic         exp_resp  = 1'b0;
  int           exp_beat  = 0;
  bit           cmp_en    = 1'b0;
  int           resp_cnt  = 0;
  logic [63:0]  wseen [4];
  logic [31:0]  addr_seen;

  localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L2 = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
                                 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};
  localparam logic [255:0] L3 = {64'h0F0F_0F0F_0000_0033, 64'h0F0F_0F0F_0000_0022,
                                 64'h0F0F_0F0F_0000_0011, 64'h0F0F_0F0F_0000_0000};
  localparam logic [255:0] W1 = {64'hCAFE_F00D_5555_AAAA, 64'hDEAD_BEEF_0000_0001,
                                 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
  localparam logic [255:0] W2 = {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                                 64'h1357_9BDF_2468_ACE0, 64'h0000_FFFF_0000_FFFF};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("line_resp",  bus.line_resp,  exp_resp);
      chk("mem_read",   bus.mem_read,   exp_rd);
      chk("mem_write",  bus.mem_write,  exp_wr);
      chk("mem_addr",   bus.mem_addr,   exp_addr);
      chk("line_rdata", bus.line_rdata, exp_rdata);
      if (exp_wr) chk("mem_wdata", bus.mem_wdata, exp_wline[exp_beat*64 +: 64]);
      if (bus.line_resp === 1'b1) resp_cnt++;
    end
  end

  // One line transaction, started from an IDLE cycle (#1 after a posedge).
  task automatic do_line(input bit is_wr, input bit rd_too, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int gap, input int abort_after,
                         input bit chain_rd, input logic [31:0] next_addr);
    bus.line_addr  = addr;
    bus.line_read  = !is_wr || rd_too;
    bus.line_write = is_wr;
    bus.line_wdata = wline;
    bus.mem_resp   = 1'b1;             // stray beat in IDLE must be ignored
    bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk); #1;
    exp_rd    = !is_wr;
    exp_wr    = is_wr;
    exp_addr  = {addr[31:5], 5'b0};
    exp_wline = wline;
    exp_beat  = 0;
    bus.line_addr  = ~addr;
    bus.line_wdata = ~wline;
    bus.mem_resp   = 1'b0;
    addr_seen      = bus.mem_addr;
    for (int b = 0; b < 4; b++) begin
      repeat (gap) begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 64'(32'($urandom));
        @(posedge clk); #1;
      end
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = rline[b*64 +: 64];
      wseen[b]      = bus.mem_wdata;
      @(posedge clk); #1;
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      if (!is_wr) exp_rdata[b*64 +: 64] = rline[b*64 +: 64];
      exp_beat = b + 1;
      if (b == 3) begin
        exp_rd   = 1'b0;
        exp_wr   = 1'b0;
        exp_resp = 1'b1;
      end
      if (abort_after == b) begin
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_rdata = '0;
        exp_addr  = '0;
        exp_rd    = 1'b0;
        exp_wr    = 1'b0;
        exp_resp  = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    // DONE cycle: a request or a beat seen here must not be taken.
    bus.line_write = 1'b0;
    bus.line_read  = chain_rd;
    bus.line_addr  = next_addr;
    bus.mem_resp   = 1'b1;
    bus.mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    exp_resp = 1'b0;
  endtask

  int r0;

  initial begin
    rst            = 1'b0;
    bus.line_addr  = '0;
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    bus.line_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_resp   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line_rdata", bus.line_rdata, '0);
    chk("rst_line_resp",  bus.line_resp,  '0);
    chk("rst_mem_addr",   bus.mem_addr,   '0);
    chk("rst_mem_read",   bus.mem_read,   '0);
    chk("rst_mem_write",  bus.mem_write,  '0);
    chk("rst_mem_wdata",  bus.mem_wdata,  '0);
    rst    = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Contiguous read.
    r0 = resp_cnt;
    do_line(1'b0, 1'b0, 32'h0000_1234, '0, L1, 0, -1, 1'b0, '0);
    chk("t1_mem_addr", addr_seen, 32'h0000_1220);
    chk("t1_line", bus.line_rdata, L1);
    chk("t1_resp_cnt", resp_cnt - r0, 1);

    // Contiguous write.
    r0 = resp_cnt;
    do_line(1'b1, 1'b0, 32'h8000_0040, W1, '0, 0, -1, 1'b0, '0);
    chk("t2_mem_addr", addr_seen, 32'h8000_0040);
    chk("t2_beat0", wseen[0], 64'h0123_4567_89AB_CDEF);
    chk("t2_beat1", wseen[1], 64'hFEDC_BA98_7654_3210);
    chk("t2_beat2", wseen[2], 64'hDEAD_BEEF_0000_0001);
    chk("t2_beat3", wseen[3], 64'hCAFE_F00D_5555_AAAA);
    chk("t2_line_kept", bus.line_rdata, L1);
    chk("t2_resp_cnt", resp_cnt - r0, 1);

    // Read with 2-cycle gaps between beats.
    r0 = resp_cnt;
    do_line(1'b0, 1'b0, 32'h0000_567F, '0, L1, 2, -1, 1'b0, '0);
    chk("t3_mem_addr", addr_seen, 32'h0000_5660);
    chk("t3_line", bus.line_rdata, L1);
    chk("t3_resp_cnt", resp_cnt - r0, 1);

    // Reset after beat 1, then a clean read from beat 0.
    r0 = resp_cnt;
    do_line(1'b0, 1'b0, 32'h0000_2000, '0, L2, 0, 1, 1'b0, '0);
    chk("t4_line_cleared", bus.line_rdata, '0);
    chk("t4_addr_cleared", bus.mem_addr, '0);
    chk("t4_no_resp", resp_cnt - r0, 0);
    do_line(1'b0, 1'b0, 32'h0000_2000, '0, L2, 1, -1, 1'b0, '0);
    chk("t4_line", bus.line_rdata, L2);

    // Read and write both requested: write wins.
    do_line(1'b1, 1'b1, 32'h4000_00A0, W2, '0, 0, -1, 1'b0, '0);
    chk("t5_mem_addr", addr_seen, 32'h4000_00A0);
    chk("t5_line_kept", bus.line_rdata, L2);

    // Write then read back-to-back; read held through DONE and taken in IDLE.
    r0 = resp_cnt;
    do_line(1'b1, 1'b0, 32'h0000_0300, W1, '0, 0, -1, 1'b1, 32'h0000_0400);
    chk("t6_line_after_wr", bus.line_rdata, L2);
    do_line(1'b0, 1'b0, 32'h0000_0400, '0, L3, 0, -1, 1'b0, '0);
    chk("t6_line", bus.line_rdata, L3);
    chk("t6_resp_cnt", resp_cnt - r0, 2);

    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
